// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX/MEM/WB register-use info and debug controls in,
// pipeline enables, flushes, state and performance counters out.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             ex_wreg;
    logic [4:0]       ex_destR;
    logic             mem_wreg;
    logic [4:0]       mem_destR;
    logic             wb_wreg;
    logic [4:0]       wb_destR;
    logic             ex_branch;
    logic             ex_zero;
    logic             dbg_halt;
    logic             dbg_step;
    logic             pc_we;
    logic             pc_sel_br;
    logic             if_id_we;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             pipe_en;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Datapath / debugger side
    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt,
        output ex_wreg, ex_destR, mem_wreg, mem_destR, wb_wreg, wb_destR,
        output ex_branch, ex_zero, dbg_halt, dbg_step,
        input  pc_we, pc_sel_br, if_id_we, if_id_flush, id_ex_flush, pipe_en,
        input  state, stall_cnt, flush_cnt
    );

    // Controller side
    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt,
        input  ex_wreg, ex_destR, mem_wreg, mem_destR, wb_wreg, wb_destR,
        input  ex_branch, ex_zero, dbg_halt, dbg_step,
        output pc_we, pc_sel_br, if_id_we, if_id_flush, id_ex_flush, pipe_en,
        output state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage CPU: RAW-hazard stalls (no forwarding in the datapath),
// taken-branch flush, debug halt/single-step, and saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter bit          WB_HAZ = 1'b0,
    parameter int unsigned CNT_W  = 32
) (
    input logic               clk,
    input logic               rst_n,
    pipe_hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        StInit = 2'b00,
        StRun  = 2'b01,
        StHalt = 2'b10,
        StStep = 2'b11
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_raw_rs;
    logic w_raw_rt;
    logic w_raw;
    logic w_tkn;
    logic w_stall_inc;
    logic w_flush_inc;
    logic w_pc_we;
    logic w_pc_sel_br;
    logic w_if_id_we;
    logic w_if_id_flush;
    logic w_id_ex_flush;
    logic w_pipe_en;

    // $0 is hard-wired, so a write to it never produces a real dependency
    function automatic logic f_match(input logic [4:0] src, input logic wr, input logic [4:0] dst);
        return wr & (dst != 5'd0) & (dst == src);
    endfunction

    // RAW detection against in-flight destinations; WB only when the regfile writes late
    always_comb begin
        w_raw_rs = f_match(bus.id_rs, bus.ex_wreg, bus.ex_destR)
                 | f_match(bus.id_rs, bus.mem_wreg, bus.mem_destR)
                 | (WB_HAZ & f_match(bus.id_rs, bus.wb_wreg, bus.wb_destR));
        w_raw_rt = f_match(bus.id_rt, bus.ex_wreg, bus.ex_destR)
                 | f_match(bus.id_rt, bus.mem_wreg, bus.mem_destR)
                 | (WB_HAZ & f_match(bus.id_rt, bus.wb_wreg, bus.wb_destR));
        w_raw    = (bus.id_use_rs & w_raw_rs) | (bus.id_use_rt & w_raw_rt);
        w_tkn    = bus.ex_branch & bus.ex_zero;
    end

    // Next state and per-cycle pipeline controls
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_we       = 1'b0;
        w_pc_sel_br   = 1'b0;
        w_if_id_we    = 1'b0;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        w_pipe_en     = 1'b0;
        w_stall_inc   = 1'b0;
        w_flush_inc   = 1'b0;
        unique case (r_state)
            StInit: begin
                w_if_id_flush = 1'b1;
                w_id_ex_flush = 1'b1;
                w_pipe_en     = 1'b1;
                w_state_nxt   = bus.dbg_halt ? StHalt : StRun;
            end
            StRun, StStep: begin
                w_pipe_en = 1'b1;
                if (w_tkn) begin
                    // Branch wins: the stalled ID instruction is on the wrong path anyway
                    w_pc_we       = 1'b1;
                    w_pc_sel_br   = 1'b1;
                    w_if_id_we    = 1'b1;
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                    w_flush_inc   = 1'b1;
                end else if (w_raw) begin
                    w_id_ex_flush = 1'b1;
                    w_stall_inc   = 1'b1;
                end else begin
                    w_pc_we    = 1'b1;
                    w_if_id_we = 1'b1;
                end
                w_state_nxt = bus.dbg_halt ? StHalt : StRun;
            end
            StHalt: begin
                // Everything frozen, so a pending hazard or branch is simply re-evaluated later
                if (!bus.dbg_halt) begin
                    w_state_nxt = StRun;
                end else if (bus.dbg_step) begin
                    w_state_nxt = StStep;
                end
            end
            default: w_state_nxt = StInit;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StInit;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_inc && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.pc_we       = w_pc_we;
    assign bus.pc_sel_br   = w_pc_sel_br;
    assign bus.if_id_we    = w_if_id_we;
    assign bus.if_id_flush = w_if_id_flush;
    assign bus.id_ex_flush = w_id_ex_flush;
    assign bus.pipe_en     = w_pipe_en;
    assign bus.state       = r_state;
    assign bus.stall_cnt   = r_stall_cnt;
    assign bus.flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: table of hazard/branch vectors plus hand sequences for reset,
// debug halt/step and counter saturation. Expected results go through a scoreboard queue.
module tb_pipe_hazard_ctrl;

    localparam int unsigned CW = 4;
    localparam logic [1:0] S_INIT = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_HALT = 2'b10;
    localparam logic [1:0] S_STEP = 2'b11;
    localparam int K_ISSUE = 0;
    localparam int K_STALL = 1;
    localparam int K_FLUSH = 2;

    typedef struct {
        string      name;
        logic [4:0] rs, rt;
        logic       use_rs, use_rt;
        logic       ex_w;
        logic [4:0] ex_d;
        logic       mem_w;
        logic [4:0] mem_d;
        logic       wb_w;
        logic [4:0] wb_d;
        logic       br, zero;
        logic       pc_we, pc_sel_br, if_id_we, if_id_flush, id_ex_flush;
        logic       wb_pc_we;
    } vec_t;

    typedef struct {
        string         name;
        logic          pc_we, pc_sel_br, if_id_we, if_id_flush, id_ex_flush, pipe_en, wb_pc_we;
        logic [1:0]    state;
        logic [CW-1:0] stall, flush;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];
    logic [CW-1:0] m_stall = '0;
    logic [CW-1:0] m_flush = '0;
    vec_t tbl[13];
    vec_t v_idle, v_haz;

    pipe_hazard_ctrl_if #(.CNT_W(CW)) if0 ();
    pipe_hazard_ctrl_if #(.CNT_W(CW)) if1 ();

    pipe_hazard_ctrl #(.WB_HAZ(1'b0), .CNT_W(CW)) u_dut (.clk(clk), .rst_n(rst_n), .bus(if0));
    pipe_hazard_ctrl #(.WB_HAZ(1'b1), .CNT_W(CW)) u_dut_wb (.clk(clk), .rst_n(rst_n), .bus(if1));

    // WB_HAZ=1 instance sees identical stimulus
    assign if1.id_rs     = if0.id_rs;
    assign if1.id_rt     = if0.id_rt;
    assign if1.id_use_rs = if0.id_use_rs;
    assign if1.id_use_rt = if0.id_use_rt;
    assign if1.ex_wreg   = if0.ex_wreg;
    assign if1.ex_destR  = if0.ex_destR;
    assign if1.mem_wreg  = if0.mem_wreg;
    assign if1.mem_destR = if0.mem_destR;
    assign if1.wb_wreg   = if0.wb_wreg;
    assign if1.wb_destR  = if0.wb_destR;
    assign if1.ex_branch = if0.ex_branch;
    assign if1.ex_zero   = if0.ex_zero;
    assign if1.dbg_halt  = if0.dbg_halt;
    assign if1.dbg_step  = if0.dbg_step;

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input string nm, input logic [4:0] rs, input logic [4:0] rt,
                                input logic urs, input logic urt,
                                input logic exw, input logic [4:0] exd,
                                input logic mw, input logic [4:0] md,
                                input logic ww, input logic [4:0] wd,
                                input logic br, input logic z, input int kind, input int wbkind);
        vec_t v;
        v.name = nm; v.rs = rs; v.rt = rt; v.use_rs = urs; v.use_rt = urt;
        v.ex_w = exw; v.ex_d = exd; v.mem_w = mw; v.mem_d = md; v.wb_w = ww; v.wb_d = wd;
        v.br = br; v.zero = z;
        v.pc_we       = (kind != K_STALL);
        v.pc_sel_br   = (kind == K_FLUSH);
        v.if_id_we    = (kind != K_STALL);
        v.if_id_flush = (kind == K_FLUSH);
        v.id_ex_flush = (kind != K_ISSUE);
        v.wb_pc_we    = (wbkind != K_STALL);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Drive one cycle, queue its expectation, compare at negedge, advance the counter model
    task automatic cyc(input vec_t v, input logic [1:0] st);
        exp_t e, g;
        if0.id_rs = v.rs; if0.id_rt = v.rt; if0.id_use_rs = v.use_rs; if0.id_use_rt = v.use_rt;
        if0.ex_wreg = v.ex_w; if0.ex_destR = v.ex_d; if0.mem_wreg = v.mem_w;
        if0.mem_destR = v.mem_d; if0.wb_wreg = v.wb_w; if0.wb_destR = v.wb_d;
        if0.ex_branch = v.br; if0.ex_zero = v.zero;
        e.name = v.name; e.state = st; e.stall = m_stall; e.flush = m_flush;
        if (st == S_RUN || st == S_STEP) begin
            e.pc_we = v.pc_we; e.pc_sel_br = v.pc_sel_br; e.if_id_we = v.if_id_we;
            e.if_id_flush = v.if_id_flush; e.id_ex_flush = v.id_ex_flush;
            e.pipe_en = 1'b1; e.wb_pc_we = v.wb_pc_we;
        end else if (st == S_HALT) begin
            e.pc_we = 0; e.pc_sel_br = 0; e.if_id_we = 0; e.if_id_flush = 0;
            e.id_ex_flush = 0; e.pipe_en = 0; e.wb_pc_we = 0;
        end else begin
            e.pc_we = 0; e.pc_sel_br = 0; e.if_id_we = 0; e.if_id_flush = 1;
            e.id_ex_flush = 1; e.pipe_en = 1; e.wb_pc_we = 0;
        end
        sb_q.push_back(e);
        @(negedge clk);
        g = sb_q.pop_front();
        chk({g.name, ".state"}, 32'(if0.state), 32'(g.state));
        chk({g.name, ".pc_we"}, 32'(if0.pc_we), 32'(g.pc_we));
        chk({g.name, ".pc_sel_br"}, 32'(if0.pc_sel_br), 32'(g.pc_sel_br));
        chk({g.name, ".if_id_we"}, 32'(if0.if_id_we), 32'(g.if_id_we));
        chk({g.name, ".if_id_flush"}, 32'(if0.if_id_flush), 32'(g.if_id_flush));
        chk({g.name, ".id_ex_flush"}, 32'(if0.id_ex_flush), 32'(g.id_ex_flush));
        chk({g.name, ".pipe_en"}, 32'(if0.pipe_en), 32'(g.pipe_en));
        chk({g.name, ".stall_cnt"}, 32'(if0.stall_cnt), 32'(g.stall));
        chk({g.name, ".flush_cnt"}, 32'(if0.flush_cnt), 32'(g.flush));
        chk({g.name, ".wb_pc_we"}, 32'(if1.pc_we), 32'(g.wb_pc_we));
        if (g.state == S_RUN || g.state == S_STEP) begin
            if (g.pc_sel_br) begin
                if (m_flush != '1) m_flush = m_flush + 1'b1;
            end else if (g.id_ex_flush) begin
                if (m_stall != '1) m_stall = m_stall + 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        //             name       rs  rt  urs urt exw exd mw md ww wd br z  kind     wbkind
        v_idle  = mk("idle",      0,  0,  0,  0,  0,  0,  0, 0, 0, 0, 0, 0, K_ISSUE, K_ISSUE);
        v_haz   = mk("ex_haz",    5,  0,  1,  0,  1,  5,  0, 0, 0, 0, 0, 0, K_STALL, K_STALL);
        tbl[0]  = mk("t_idle",    0,  0,  0,  0,  0,  0,  0, 0, 0, 0, 0, 0, K_ISSUE, K_ISSUE);
        tbl[1]  = mk("t_ex_rs",   5,  0,  1,  0,  1,  5,  0, 0, 0, 0, 0, 0, K_STALL, K_STALL);
        tbl[2]  = mk("t_mem_rs",  5,  0,  1,  0,  0,  0,  1, 5, 0, 0, 0, 0, K_STALL, K_STALL);
        tbl[3]  = mk("t_issue",   5,  0,  1,  0,  0,  0,  0, 0, 0, 0, 0, 0, K_ISSUE, K_ISSUE);
        tbl[4]  = mk("t_reg0",    0,  0,  1,  0,  1,  0,  1, 0, 0, 0, 0, 0, K_ISSUE, K_ISSUE);
        tbl[5]  = mk("t_wb_rt",   0,  7,  0,  1,  0,  0,  0, 0, 1, 7, 0, 0, K_ISSUE, K_STALL);
        tbl[6]  = mk("t_ex_rt",   0,  9,  0,  1,  1,  9,  0, 0, 0, 0, 0, 0, K_STALL, K_STALL);
        tbl[7]  = mk("t_no_use",  0,  9,  0,  0,  1,  9,  0, 0, 0, 0, 0, 0, K_ISSUE, K_ISSUE);
        tbl[8]  = mk("t_no_wr",   0,  9,  0,  1,  0,  9,  0, 9, 0, 9, 0, 0, K_ISSUE, K_ISSUE);
        tbl[9]  = mk("t_br_raw",  5,  0,  1,  0,  1,  5,  0, 0, 0, 0, 1, 1, K_FLUSH, K_FLUSH);
        tbl[10] = mk("t_br_nt",   0,  0,  0,  0,  0,  0,  0, 0, 0, 0, 1, 0, K_ISSUE, K_ISSUE);
        tbl[11] = mk("t_zero",    0,  0,  0,  0,  0,  0,  0, 0, 0, 0, 0, 1, K_ISSUE, K_ISSUE);
        tbl[12] = mk("t_mem_rt",  0,  3,  0,  1,  0,  0,  1, 3, 1, 4, 0, 0, K_STALL, K_STALL);

        if0.dbg_halt = 1'b0;
        if0.dbg_step = 1'b0;
        rst_n = 1'b0;
        #1;
        cyc(v_idle, S_INIT);             // held in reset
        rst_n = 1'b1;
        cyc(v_idle, S_INIT);             // one INIT cycle after release

        foreach (tbl[i]) cyc(tbl[i], S_RUN);

        // Step is ignored outside HALT
        if0.dbg_step = 1'b1;
        cyc(v_idle, S_RUN);
        cyc(v_idle, S_RUN);
        if0.dbg_step = 1'b0;

        // Halt: the requesting RUN cycle still executes, then a pending hazard is frozen
        if0.dbg_halt = 1'b1;
        cyc(v_idle, S_RUN);
        cyc(v_haz, S_HALT);
        if0.dbg_step = 1'b1;
        cyc(v_idle, S_HALT);
        if0.dbg_step = 1'b0;
        cyc(v_idle, S_STEP);
        cyc(v_idle, S_HALT);
        // Step held high alternates STEP and HALT
        if0.dbg_step = 1'b1;
        cyc(v_idle, S_HALT);
        cyc(v_haz, S_STEP);
        cyc(v_idle, S_HALT);
        if0.dbg_step = 1'b0;
        cyc(v_idle, S_STEP);
        cyc(v_idle, S_HALT);
        if0.dbg_halt = 1'b0;
        cyc(v_idle, S_HALT);
        cyc(v_idle, S_RUN);

        // Stall counter saturates at all-ones
        for (int i = 0; i < 20; i++) cyc(v_haz, S_RUN);
        chk("sat_stall_model", 32'(if0.stall_cnt), 32'hF);

        // Asynchronous reset in the middle of a stall
        if0.id_rs = 5'd5; if0.id_use_rs = 1'b1; if0.ex_wreg = 1'b1; if0.ex_destR = 5'd5;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid.state", 32'(if0.state), 32'(S_INIT));
        chk("rst_mid.stall_cnt", 32'(if0.stall_cnt), 32'h0);
        chk("rst_mid.flush_cnt", 32'(if0.flush_cnt), 32'h0);
        chk("rst_mid.pc_we", 32'(if0.pc_we), 32'h0);
        chk("rst_mid.id_ex_flush", 32'(if0.id_ex_flush), 32'h1);
        m_stall = '0;
        m_flush = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(v_haz, S_INIT);
        cyc(v_haz, S_RUN);
        cyc(v_idle, S_RUN);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
